// File: rtl/commit_queue.sv
// ---------------------------------------------------------------------------
// commit_queue
//   Retire-side buffer in front of the difftest stage. Accepts one retired
//   instruction per cycle into a DEPTH-entry FIFO and drains one per cycle
//   while difftest allows it. Each drained entry updates a shadow GPR file
//   and raises a one-cycle step pulse. The snapshot on gpr_* therefore always
//   reflects exactly the instructions retired so far. Applying an ebreak
//   freezes the queue until reset.
//
//   Optional feature macro: COMMIT_QUEUE_BYPASS_EN
//     When defined, an instruction arriving at an empty queue while drain_en
//     is high is applied at the acceptance edge and skips storage. This gives
//     1-cycle latency. When undefined, every entry goes through storage first
//     and latency is 2 cycles.
//
//   Ports
//     clock, reset          : clock; synchronous active-high reset
//     in_valid / in_ready   : retire handshake from write-back
//     in_pc, in_inst        : pc and instruction word of the retired instruction
//     in_rd_wen/addr/data   : destination register write
//     in_ebreak             : instruction is ebreak
//     drain_en              : difftest may consume one commit this cycle
//     step_valid/pc/inst    : one-cycle pulse and the identity of the applied commit
//     gpr_0 .. gpr_31       : registered shadow architectural GPRs
//     halted                : sticky; set once an ebreak has been applied
//     commit_cnt            : number of applied commits (wraps at 2^64)
//     level                 : current FIFO occupancy
// ---------------------------------------------------------------------------
module commit_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [XLEN-1:0]              in_pc,
   input  logic [31:0]                  in_inst,
   input  logic                         in_rd_wen,
   input  logic [4:0]                   in_rd_addr,
   input  logic [XLEN-1:0]              in_rd_data,
   input  logic                         in_ebreak,
   input  logic                         drain_en,
   output logic                         step_valid,
   output logic [XLEN-1:0]              step_pc,
   output logic [31:0]                  step_inst,
   output logic [XLEN-1:0]              gpr_0,
   output logic [XLEN-1:0]              gpr_1,
   output logic [XLEN-1:0]              gpr_2,
   output logic [XLEN-1:0]              gpr_3,
   output logic [XLEN-1:0]              gpr_4,
   output logic [XLEN-1:0]              gpr_5,
   output logic [XLEN-1:0]              gpr_6,
   output logic [XLEN-1:0]              gpr_7,
   output logic [XLEN-1:0]              gpr_8,
   output logic [XLEN-1:0]              gpr_9,
   output logic [XLEN-1:0]              gpr_10,
   output logic [XLEN-1:0]              gpr_11,
   output logic [XLEN-1:0]              gpr_12,
   output logic [XLEN-1:0]              gpr_13,
   output logic [XLEN-1:0]              gpr_14,
   output logic [XLEN-1:0]              gpr_15,
   output logic [XLEN-1:0]              gpr_16,
   output logic [XLEN-1:0]              gpr_17,
   output logic [XLEN-1:0]              gpr_18,
   output logic [XLEN-1:0]              gpr_19,
   output logic [XLEN-1:0]              gpr_20,
   output logic [XLEN-1:0]              gpr_21,
   output logic [XLEN-1:0]              gpr_22,
   output logic [XLEN-1:0]              gpr_23,
   output logic [XLEN-1:0]              gpr_24,
   output logic [XLEN-1:0]              gpr_25,
   output logic [XLEN-1:0]              gpr_26,
   output logic [XLEN-1:0]              gpr_27,
   output logic [XLEN-1:0]              gpr_28,
   output logic [XLEN-1:0]              gpr_29,
   output logic [XLEN-1:0]              gpr_30,
   output logic [XLEN-1:0]              gpr_31,
   output logic                         halted,
   output logic [63:0]                  commit_cnt,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            wen;
      logic [4:0]      addr;
      logic [XLEN-1:0] data;
      logic            ebreak;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [XLEN-1:0]   gpr_q [32];
   logic [XLEN-1:0]   gpr_d [32];
   logic              step_valid_q, step_valid_d;
   logic [XLEN-1:0]   step_pc_q, step_pc_d;
   logic [31:0]       step_inst_q, step_inst_d;
   logic              halted_q, halted_d;
   logic [63:0]       commit_cnt_q, commit_cnt_d;

   logic    full, empty, enq, deq, bypass, store, apply;
   entry_t  inc, src;

   assign full     = (level_q == LVL_W'(DEPTH));
   assign empty    = (level_q == '0);
   assign in_ready = !full && !halted_q;
   assign enq      = in_valid && in_ready;
   assign deq      = !empty && drain_en && !halted_q;

`ifdef COMMIT_QUEUE_BYPASS_EN
   // Empty queue and difftest ready: apply the arriving instruction directly.
   assign bypass = empty && enq && drain_en && !halted_q;
`else
   assign bypass = 1'b0;
`endif

   assign store = enq && !bypass;
   assign apply = deq || bypass;

   always_comb begin
      inc.pc     = in_pc;
      inc.inst   = in_inst;
      inc.wen    = in_rd_wen;
      inc.addr   = in_rd_addr;
      inc.data   = in_rd_data;
      inc.ebreak = in_ebreak;

      // deq and bypass are mutually exclusive: bypass requires an empty queue.
      src = bypass ? inc : ent_q[head_q];

      ent_d        = ent_q;
      head_d       = head_q;
      tail_d       = tail_q;
      level_d      = level_q;
      gpr_d        = gpr_q;
      step_valid_d = apply;
      step_pc_d    = step_pc_q;
      step_inst_d  = step_inst_q;
      halted_d     = halted_q;
      commit_cnt_d = commit_cnt_q;

      if (store) begin
         ent_d[tail_q] = inc;
         tail_d        = tail_q + 1'b1;
      end
      if (deq) begin
         head_d = head_q + 1'b1;
      end

      case ({store, deq})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      if (apply) begin
         step_pc_d    = src.pc;
         step_inst_d  = src.inst;
         commit_cnt_d = commit_cnt_q + 64'd1;
         // x0 is architecturally zero, so writes to it are dropped.
         if (src.wen && (src.addr != 5'd0)) begin
            gpr_d[src.addr] = src.data;
         end
         if (src.ebreak) begin
            halted_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         for (int i = 0; i < 32; i++)    gpr_q[i] <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         level_q      <= '0;
         step_valid_q <= 1'b0;
         step_pc_q    <= '0;
         step_inst_q  <= '0;
         halted_q     <= 1'b0;
         commit_cnt_q <= '0;
      end else begin
         ent_q        <= ent_d;
         gpr_q        <= gpr_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         level_q      <= level_d;
         step_valid_q <= step_valid_d;
         step_pc_q    <= step_pc_d;
         step_inst_q  <= step_inst_d;
         halted_q     <= halted_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   assign step_valid = step_valid_q;
   assign step_pc    = step_pc_q;
   assign step_inst  = step_inst_q;
   assign halted     = halted_q;
   assign commit_cnt = commit_cnt_q;
   assign level      = level_q;

   assign gpr_0  = gpr_q[0];
   assign gpr_1  = gpr_q[1];
   assign gpr_2  = gpr_q[2];
   assign gpr_3  = gpr_q[3];
   assign gpr_4  = gpr_q[4];
   assign gpr_5  = gpr_q[5];
   assign gpr_6  = gpr_q[6];
   assign gpr_7  = gpr_q[7];
   assign gpr_8  = gpr_q[8];
   assign gpr_9  = gpr_q[9];
   assign gpr_10 = gpr_q[10];
   assign gpr_11 = gpr_q[11];
   assign gpr_12 = gpr_q[12];
   assign gpr_13 = gpr_q[13];
   assign gpr_14 = gpr_q[14];
   assign gpr_15 = gpr_q[15];
   assign gpr_16 = gpr_q[16];
   assign gpr_17 = gpr_q[17];
   assign gpr_18 = gpr_q[18];
   assign gpr_19 = gpr_q[19];
   assign gpr_20 = gpr_q[20];
   assign gpr_21 = gpr_q[21];
   assign gpr_22 = gpr_q[22];
   assign gpr_23 = gpr_q[23];
   assign gpr_24 = gpr_q[24];
   assign gpr_25 = gpr_q[25];
   assign gpr_26 = gpr_q[26];
   assign gpr_27 = gpr_q[27];
   assign gpr_28 = gpr_q[28];
   assign gpr_29 = gpr_q[29];
   assign gpr_30 = gpr_q[30];
   assign gpr_31 = gpr_q[31];

endmodule

// File: doc/commit_queue.md
Name: commit_queue

Overview:
- Retire-side buffer directly upstream of the difftest stage.
- Accepts one retired instruction per cycle from write-back (pc, inst, rd write, ebreak) into a small FIFO.
- Drains one entry per cycle when difftest permits, applying each rd write to a shadow GPR array.
- Emits a one-cycle step pulse together with a 32-entry GPR snapshot that is consistent with exactly the instructions retired so far.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- XLEN, 64, data width of GPRs, rd_data and pc.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  write-back presents a retired instruction.
- in_ready  output  1  queue can accept; in_ready = !full && !halted.
- in_pc  input  XLEN  pc of retired instruction.
- in_inst  input  32  instruction word.
- in_rd_wen  input  1  instruction writes rd.
- in_rd_addr  input  5  destination register.
- in_rd_data  input  XLEN  value written to rd.
- in_ebreak  input  1  instruction is ebreak (simulation end).
- drain_en  input  1  difftest allows one commit to be consumed this cycle.
- step_valid  output  1  one-cycle pulse: one commit applied; step_* and gpr_* describe post-commit state.
- step_pc  output  XLEN  pc of the applied commit.
- step_inst  output  32  inst of the applied commit.
- gpr_0 .. gpr_31  output  XLEN each  shadow architectural GPRs, registered.
- halted  output  1  sticky; set when an ebreak entry is applied.
- commit_cnt  output  64  number of applied commits.
- level  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO empty: level=0, in_ready=1.
  - step_valid=0, step_pc=0, step_inst=0.
  - All gpr_*=0, halted=0, commit_cnt=0.
  - Reset asserted mid-operation discards all queued entries at that edge.
- Enqueue: on in_valid && in_ready, write entry at tail; tail pointer wraps modulo DEPTH.
- Dequeue condition: deq = !empty && drain_en && !halted.
- On deq edge:
  - Pop head; head pointer wraps modulo DEPTH.
  - If rd_wen && rd_addr != 0, gpr[rd_addr] <= rd_data. A write to x0 is dropped; gpr_0 is always 0.
  - step_valid <= 1; step_pc and step_inst load from the head entry.
  - commit_cnt increments, wrapping at 2^64.
  - If the entry's ebreak=1, halted <= 1.
- Cycles without deq: step_valid <= 0; step_pc, step_inst and gpr_* hold their values.
- Full (level=DEPTH): in_ready=0, even if a dequeue occurs in the same cycle. There is no write-through when full.
- Simultaneous enqueue and dequeue when 0 < level < DEPTH: level is unchanged.
- Empty: no dequeue, step_valid=0 next cycle.
- Latency, no bypass: entry accepted at edge E is at the head after E, dequeued at the next edge E+1 if drain_en, and step_valid is high in the cycle following E+1. That is 2 cycles from in_valid to step_valid.
- Halted:
  - in_ready=0 and no further deq.
  - Entries behind the ebreak stay queued and are never applied.
  - Only reset clears halted.
- Throughput: 1 commit/cycle sustained while drain_en=1.

Optional Feature:
- Macro: COMMIT_QUEUE_BYPASS_EN
- Defined:
  - When level=0 and in_valid && in_ready && drain_en && !halted, the incoming entry is applied directly at that edge (gpr update, step_* load, counters, halted) without being written to storage. level stays 0.
  - Latency is 1 cycle (step_valid high the cycle after acceptance).
  - Ordering is unchanged otherwise.
- Undefined: latency is always 2 cycles; storage is always written first.

Test Plan:
- Reset then idle: all gpr_*=0, level=0, in_ready=1, step_valid=0 for 10 cycles.
- Single commit: pc=0x80000000, inst=0x00500093, rd=1, data=5, drain_en=1 -> step_valid pulses 2 cycles later (1 with BYPASS_EN), step_pc=0x80000000, gpr_1=5, commit_cnt=1.
- x0 write: rd=0, data=0xDEADBEEF -> gpr_0 stays 0, step_valid still pulses, commit_cnt increments.
- Backpressure: drain_en=0, push 4 entries (DEPTH=4) -> level=4, in_ready=0, 5th in_valid not accepted. Then drain_en=1 -> 4 step pulses in consecutive cycles, pcs in order, in_ready=1 after first deq.
- Wrap: sustained streaming of 10 commits with drain_en toggled 1,0,1,… -> all 10 applied in order, pointers wrap, no loss/duplication, commit_cnt=10.
- Ebreak: queue [addi x2=7, ebreak, addi x3=9] -> gpr_2=7, halted=1 after second step, gpr_3 stays 0, in_ready=0. Reset mid-stream clears everything next cycle.
